// File: rtl/lzw_decoder.sv
// LZW decoder: codes in, decoded bytes out in forward order via a LIFO.
// Latency: literal emits the cycle after acceptance; each stored link costs 2 cycles, the literal root 1 more.
// Backpressure: code_ready only in IDLE; byte_out held while byte_ready=0.
// Ports: clk/rst_n (async active-low); code_in/code_valid/code_ready code stream;
//        byte_out/byte_valid/byte_ready byte stream; next_code_out, dict_full, err_bad_code status.
module lzw_decoder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] next_code_out,
  output logic                  dict_full,
  output logic                  err_bad_code
);

  localparam int DICT_N = DEPTH - 256;
  localparam logic [ADDR_WIDTH-1:0] LIT_LIM   = ADDR_WIDTH'(256);
  localparam logic [ADDR_WIDTH-1:0] LAST_CODE = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RD, PUSH, EMIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] code_q, code_d;
  logic [ADDR_WIDTH-1:0] prev_q;
  logic                  prev_vld_q;
  logic [ADDR_WIDTH-1:0] next_code_q;
  logic                  dict_full_q;
  logic [7:0]            first_char_q;
  logic [ADDR_WIDTH-1:0] sp_q;
  logic                  err_q, err_d;

  logic                  code_ok;
  logic                  push_en;
  logic [7:0]            push_dat;
  logic                  pop_en;
  logic                  enter_emit;
  logic                  dict_we;

  // Dictionary holds codes 256..DEPTH-1 only, indexed by code-256.
  logic [ADDR_WIDTH-1:0] dict_pfx [DICT_N];
  logic [7:0]            dict_chr [DICT_N];
  logic [ADDR_WIDTH-1:0] rd_pfx_q;
  logic [7:0]            rd_chr_q;
  logic [7:0]            lifo [DEPTH];

  assign code_ready    = (state_q == IDLE);
  assign byte_valid    = (state_q == EMIT);
  assign byte_out      = (state_q == EMIT) ? lifo[sp_q - ONE] : 8'h00;
  assign next_code_out = next_code_q;
  assign dict_full     = dict_full_q;
  assign err_bad_code  = err_q;

  // Without a previous code only literals make sense; otherwise the code may
  // be the one about to be assigned (KwKwK), unless the table is frozen.
  always_comb begin
    code_ok = 1'b0;
    if (!prev_vld_q)      code_ok = (code_in < LIT_LIM);
    else if (dict_full_q) code_ok = (code_in < next_code_q);
    else                  code_ok = (code_in <= next_code_q);
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    code_d   = code_q;
    push_en  = 1'b0;
    push_dat = 8'h00;
    pop_en   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (code_valid) begin
          if (!code_ok) begin
            err_d = 1'b1;
          end else begin
            code_d = code_in;
            if (code_in < LIT_LIM) begin
              push_en  = 1'b1;
              push_dat = code_in[7:0];
              state_d  = EMIT;
            end else if (code_in == next_code_q) begin
              // KwKwK: trailing char is the first char of the previous string,
              // the rest is the previous string itself.
              push_en  = 1'b1;
              push_dat = first_char_q;
              cur_d    = prev_q;
              state_d  = RD;
            end else begin
              cur_d   = code_in;
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        // A literal reached while walking is the string root.
        if (cur_q < LIT_LIM) begin
          push_en  = 1'b1;
          push_dat = cur_q[7:0];
          state_d  = EMIT;
        end else begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        push_en  = 1'b1;
        push_dat = rd_chr_q;
        cur_d    = rd_pfx_q;
        state_d  = RD;
      end
      EMIT: begin
        if (byte_ready) begin
          pop_en = 1'b1;
          if (sp_q == ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every transition into EMIT pushes the root byte, so push_dat is the
  // first char of the string just decoded.
  assign enter_emit = (state_q != EMIT) && (state_d == EMIT);
  assign dict_we    = enter_emit && prev_vld_q && !dict_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      code_q       <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      next_code_q  <= LIT_LIM;
      dict_full_q  <= 1'b0;
      first_char_q <= 8'h00;
      sp_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      code_q  <= code_d;
      err_q   <= err_d;
      if (push_en)     sp_q <= sp_q + ONE;
      else if (pop_en) sp_q <= sp_q - ONE;
      if (enter_emit) begin
        first_char_q <= push_dat;
        prev_q       <= code_d;
        prev_vld_q   <= 1'b1;
      end
      if (dict_we) begin
        if (next_code_q == LAST_CODE) dict_full_q <= 1'b1;
        else                          next_code_q <= next_code_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) lifo[sp_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (dict_we) begin
      dict_pfx[next_code_q - LIT_LIM] <= prev_q;
      dict_chr[next_code_q - LIT_LIM] <= push_dat;
    end
    if (state_q == RD && cur_q >= LIT_LIM) begin
      rd_pfx_q <= dict_pfx[cur_q - LIT_LIM];
      rd_chr_q <= dict_chr[cur_q - LIT_LIM];
    end
  end

endmodule

// File: tb/tb_lzw_decoder.sv
module tb_lzw_decoder;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] code_in = '0;
  logic          code_valid = 1'b0;
  logic          code_ready;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] next_code_out;
  logic          dict_full;
  logic          err_bad_code;

  lzw_decoder #(.ADDR_WIDTH(AW), .DEPTH(2048)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .next_code_out(next_code_out),
    .dict_full(dict_full), .err_bad_code(err_bad_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // byte_ready generator: single writer, changes shortly after posedge.
  logic stall_en = 1'b0;
  logic ready_level = 1'b1;
  int   stall_ph = 0;
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stall_en) begin
        stall_ph = (stall_ph + 1) % 4;
        byte_ready = (stall_ph == 0);
      end else begin
        byte_ready = ready_level;
      end
    end
  end

  // Output monitor: collects popped bytes and error pulses.
  logic [7:0] rx[$];
  int err_total = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) rx.push_back(byte_out);
      if (err_bad_code) err_total++;
    end
  end

  // Stall / busy observer.
  logic pv_vld = 1'b0, pv_rdy = 1'b0;
  logic [7:0] pv_dat = 8'h00;
  int stall_cyc = 0, stall_bad = 0, busy_bad = 0;
  always @(negedge clk) begin
    if (rst_n && pv_vld && !pv_rdy && byte_valid) begin
      stall_cyc++;
      if (byte_out !== pv_dat) stall_bad++;
    end
    if (byte_valid && code_ready) busy_bad++;
    pv_vld = byte_valid && rst_n;
    pv_rdy = byte_ready;
    pv_dat = byte_out;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    code_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int c);
    int n;
    n = 0;
    code_in = AW'(c);
    code_valid = 1'b1;
    while (!code_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) chk("send_timeout", 32'(c), 32'hFFFF_FFFF);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(code_ready && !byte_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(code_ready && !byte_valid)) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  typedef struct {
    int              code;
    int              nb;
    logic [3:0][7:0] b;     // byte k is b[3-k]
    int              err;
    int              nxt;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int c, input int nb, input logic [31:0] b,
                              input int e, input int nx);
    vec_t v;
    v.code = c; v.nb = nb; v.b = b; v.err = e; v.nxt = nx;
    return v;
  endfunction

  task automatic expect_bytes(input string name, input int base, input int nb,
                              input logic [31:0] bytes);
    logic [3:0][7:0] b;
    b = bytes;
    chk({name, "_count"}, 32'(rx.size() - base), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      if (base + k < rx.size()) chk({name, "_byte"}, 32'(rx[base + k]), 32'(b[3 - k]));
      else                      chk({name, "_byte_missing"}, 32'hFFFF_FFFF, 32'(b[3 - k]));
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0;

    // One continuous stream after reset; each row's expectations depend on the rows before.
    vecs[0] = mk(65,  1, 32'h41_00_00_00, 0, 256);
    vecs[1] = mk(66,  1, 32'h42_00_00_00, 0, 257);
    vecs[2] = mk(256, 2, 32'h41_42_00_00, 0, 258);
    vecs[3] = mk(257, 2, 32'h42_41_00_00, 0, 259);
    vecs[4] = mk(259, 3, 32'h42_41_42_00, 0, 260);  // KwKwK on "BA"
    vecs[5] = mk(261, 0, 32'h00_00_00_00, 1, 260);  // beyond next_code
    vecs[6] = mk(258, 3, 32'h41_42_42_00, 0, 261);
    vecs[7] = mk(260, 4, 32'h42_41_42_41, 0, 262);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_code_ready", 32'(code_ready), 32'd1);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_err", 32'(err_bad_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_code_ready", 32'(code_ready), 32'd1);
    chk("rel_byte_valid", 32'(byte_valid), 32'd0);
    chk("rel_next_code", 32'(next_code_out), 32'd256);
    chk("rel_dict_full", 32'(dict_full), 32'd0);

    // Table-driven stream
    for (int i = 0; i < 8; i++) begin
      base = rx.size();
      e0 = err_total;
      send(vecs[i].code);
      wait_idle();
      chk($sformatf("vec%0d_err", i), 32'(err_total - e0), 32'(vecs[i].err));
      expect_bytes($sformatf("vec%0d", i), base, vecs[i].nb, vecs[i].b);
      chk($sformatf("vec%0d_next", i), 32'(next_code_out), 32'(vecs[i].nxt));
    end

    // KwKwK straight after reset
    do_reset();
    base = rx.size();
    send(65); send(256); wait_idle();
    expect_bytes("kwk", base, 3, 32'h41_41_41_00);
    chk("kwk_next", 32'(next_code_out), 32'd257);

    // Bad codes after reset, literal latency
    do_reset();
    base = rx.size(); e0 = err_total;
    send(300); wait_idle();
    chk("bad_first_err", 32'(err_total - e0), 32'd1);
    chk("bad_first_nobyte", 32'(rx.size() - base), 32'd0);
    code_in = AW'(65); code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    chk("lit_latency_valid", 32'(byte_valid), 32'd1);
    chk("lit_latency_byte", 32'(byte_out), 32'h41);
    wait_idle();
    e0 = err_total;
    send(400); wait_idle();
    chk("bad_400_err", 32'(err_total - e0), 32'd1);
    expect_bytes("bad_seq", base, 1, 32'h41_00_00_00);
    chk("bad_next", 32'(next_code_out), 32'd256);

    // Output stalls: 3 low cycles per byte
    do_reset();
    base = rx.size();
    stall_en = 1'b1;
    send(65); send(66); send(256); wait_idle();
    stall_en = 1'b0;
    expect_bytes("stall", base, 4, 32'h41_42_41_42);
    chk("stall_seen", 32'(stall_cyc > 0), 32'd1);
    chk("stall_stable", 32'(stall_bad), 32'd0);

    // Fill the dictionary
    do_reset();
    base = rx.size();
    for (int i = 0; i < 1792; i++) send(65);
    wait_idle();
    chk("fill_1791_full", 32'(dict_full), 32'd0);
    chk("fill_1791_next", 32'(next_code_out), 32'd2047);
    send(65); wait_idle();
    chk("fill_full", 32'(dict_full), 32'd1);
    chk("fill_next", 32'(next_code_out), 32'd2047);
    chk("fill_bytes", 32'(rx.size() - base), 32'd1793);
    e0 = err_total; base = rx.size();
    send(2047); wait_idle();
    chk("full_2047_err", 32'(err_total - e0), 32'd1);
    chk("full_2047_nobyte", 32'(rx.size() - base), 32'd0);
    e0 = err_total;
    send(2046); wait_idle();
    chk("full_2046_err", 32'(err_total - e0), 32'd0);
    expect_bytes("full_2046", base, 2, 32'h41_41_00_00);
    chk("full_no_write", 32'(next_code_out), 32'd2047);

    // Reset in the middle of EMIT
    ready_level = 1'b0;
    repeat (2) @(negedge clk);
    send(2046);
    for (int n = 0; n < 20 && !byte_valid; n++) @(negedge clk);
    chk("mid_emit_reached", 32'(byte_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_next", 32'(next_code_out), 32'd256);
    chk("mid_rst_full", 32'(dict_full), 32'd0);
    chk("mid_rst_code_ready", 32'(code_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ready_level = 1'b1;
    repeat (2) @(negedge clk);
    base = rx.size();
    send(65); wait_idle();
    expect_bytes("post_rst", base, 1, 32'h41_00_00_00);

    chk("busy_while_emit", 32'(busy_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
